data_sync_mc: RTL and testbench
===============================

DATA_SYNC_MC -- requirements
Module: data_sync_mc

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 8: data bits per channel.
REQ-002 SHALL have parameter NUM_STAGES, default 2: synchroniser flop count per enable, minimum 2.
REQ-003 SHALL have parameter NUM_CH, default 4: number of independent source channels, minimum 1.
REQ-004 SHALL have port clk  input  1: single destination-domain clock; one clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port Unsync_bus  input  NUM_CH*BUS_WIDTH: unsynchronised data; channel c occupies bits [c*BUS_WIDTH +: BUS_WIDTH].
REQ-007 SHALL have port bus_enable  input  NUM_CH: per-channel asynchronous level enable; the source holds data stable while it is high.
REQ-008 SHALL have port err_clr  input  NUM_CH: per-channel overrun clear.
REQ-009 SHALL have port out_ready  input  1: consumer accepts the output word.
REQ-010 SHALL have port sync_bus  output  BUS_WIDTH: delivered data word.
REQ-011 SHALL have port sync_ch  output  CH_W: source channel of sync_bus; CH_W = max(1, clog2(NUM_CH)).
REQ-012 SHALL have port out_valid  output  1: sync_bus/sync_ch hold a word not yet accepted.
REQ-013 SHALL have port enable_pulse  output  1: one-cycle pulse on every load of the output register.
REQ-014 SHALL have port overrun  output  NUM_CH: sticky per-channel overrun flags.
REQ-015 SHALL have port ack  output  NUM_CH: per-channel 4-phase acknowledge level.

Function
REQ-016 SHALL pass each bus_enable bit through NUM_STAGES flops (en_s), then one more flop (en_d); capture edge = en_s & ~en_d.
REQ-017 SHALL, on a capture edge for channel c with pending[c]=0, load hold[c] from the channel c slice of Unsync_bus and set pending[c] at that clock edge; latency from the first bus_enable-high sample to pending set = NUM_STAGES+1 cycles.
REQ-018 SHALL, on a capture edge while pending[c]=1 and channel c is not being granted in that cycle, discard the new data, keep hold[c], and set overrun[c].
REQ-019 SHALL treat a capture edge coinciding with a grant of channel c as a normal capture: the old hold[c] is delivered, the new data loads, pending[c] stays 1, and overrun is not set.
REQ-020 SHALL grant when (out_valid=0 or out_ready=1) and any pending bit is set; the granted channel is the first pending index at or after rr_ptr, wrapping modulo NUM_CH.
REQ-021 SHALL, on grant g: load sync_bus=hold[g], sync_ch=g; set out_valid=1; pulse enable_pulse for 1 cycle; clear pending[g] (except as in REQ-019); set rr_ptr=(g+1) mod NUM_CH.
REQ-022 SHALL clear out_valid when out_ready=1 and there is no grant; sync_bus and sync_ch hold their last value when out_valid=0.
REQ-023 SHALL hold sync_bus, sync_ch and out_valid unchanged while out_valid=1 and out_ready=0.
REQ-024 SHALL sustain one delivery per cycle with back-to-back grants when out_ready is held high.
REQ-025 SHALL clear overrun[c] on err_clr[c]=1; a simultaneous set wins over the clear.
REQ-026 SHALL, for NUM_CH=1, tie sync_ch to 0 and make rr_ptr constant 0.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, clear all sync flops, en_d, pending, hold, rr_ptr, sync_bus, sync_ch, out_valid, enable_pulse, overrun and ack to 0.
REQ-028 SHALL discard in-flight and pending words on reset mid-operation; an enable still high after reset produces a fresh capture after NUM_STAGES+1 cycles.

Configuration
REQ-029 SHALL compile the acknowledge logic only when macro DATA_SYNC_MC_ACK_EN is defined.
REQ-030 SHALL, with DATA_SYNC_MC_ACK_EN defined, set ack[c] on the cycle channel c is granted and clear ack[c] when en_s[c]=0.
REQ-031 SHALL, without DATA_SYNC_MC_ACK_EN, drive ack to constant 0 with no flops.

Structure
REQ-032 SHALL place the CH_W width function and the reset constants in shared package data_sync_pkg.
REQ-033 SHALL instantiate the existing BIT_SYNC sub-module, width 1 and NUM_STAGES stages, once per channel; arbitration and holding logic stay in data_sync_mc.

Verification
REQ-034 SHALL verify single capture: ch2 data 0xA5 with bus_enable[2] rising and out_ready=1 -> enable_pulse exactly 4 cycles later (NUM_STAGES=2), sync_bus=0xA5, sync_ch=2.
REQ-035 SHALL verify round robin: ch0..3 enables rise in the same cycle with out_ready=1 -> deliveries in order 0,1,2,3 on consecutive cycles; then ch1 and ch0 rise together -> ch0 delivered before ch1.
REQ-036 SHALL verify backpressure: out_ready=0 with two pending channels -> out_valid=1 and sync_bus stable for 10 cycles; out_ready=1 -> next word delivered in the following cycle.
REQ-037 SHALL verify overrun: ch1 0x11 captured with out_ready=0, then ch1 toggles and presents 0x22 -> overrun[1]=1 and delivered data 0x11; err_clr[1] pulse -> overrun[1]=0.
REQ-038 SHALL verify reset mid-operation: rst asserted with three words pending -> all outputs 0 next cycle and no stale word delivered afterwards.
REQ-039 SHALL verify DATA_SYNC_MC_ACK_EN: ack[3] rises on the grant of ch3 and falls 2 cycles after bus_enable[3] falls; without the macro, ack stays 0 throughout.

Source files
------------

// File: rtl/data_sync_pkg.sv
// Shared definitions for the multi-channel data synchroniser: the channel-index
// width helper and the value every register takes while rst is high.
package data_sync_pkg;

  // Channel index width; a single channel still needs one bit on sync_ch.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Reset level for every flop in the data_sync_mc slice.
  localparam logic RST_BIT = 1'b0;

endpackage

// File: rtl/data_sync_mc_bit_sync.sv
// BIT_SYNC: plain flop-chain synchroniser, WIDTH bits, NUM_STAGES deep.
module BIT_SYNC #(
  parameter int WIDTH      = 1,
  parameter int NUM_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);
  import data_sync_pkg::*;

  logic [WIDTH-1:0] stage_reg [NUM_STAGES];

  // Shift the asynchronous input through the stage chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_STAGES; i++) stage_reg[i] <= {WIDTH{RST_BIT}};
    end else begin
      stage_reg[0] <= async_in;
      for (int i = 1; i < NUM_STAGES; i++) stage_reg[i] <= stage_reg[i-1];
    end
  end

  assign sync_out = stage_reg[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_mc.sv
// data_sync_mc: per-channel enable synchronisers feeding one-deep holding
// registers, round-robin arbitrated onto a single valid/ready output word.
// Optional 4-phase acknowledge compiled in with `define DATA_SYNC_MC_ACK_EN.
module data_sync_mc
  import data_sync_pkg::*;
#(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2,
  parameter int NUM_CH     = 4,
  localparam int CH_W      = ch_w(NUM_CH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH*BUS_WIDTH-1:0] Unsync_bus,
  input  logic [NUM_CH-1:0]           bus_enable,
  input  logic [NUM_CH-1:0]           err_clr,
  input  logic                        out_ready,
  output logic [BUS_WIDTH-1:0]        sync_bus,
  output logic [CH_W-1:0]             sync_ch,
  output logic                        out_valid,
  output logic                        enable_pulse,
  output logic [NUM_CH-1:0]           overrun,
  output logic [NUM_CH-1:0]           ack
);

  logic [NUM_CH-1:0]    en_s;
  logic [NUM_CH-1:0]    en_d_reg;
  logic [NUM_CH-1:0]    cap;
  logic [NUM_CH-1:0]    pending_reg, pending_next;
  logic [NUM_CH-1:0]    overrun_reg, overrun_next;
  logic [NUM_CH-1:0]    load_hold;
  logic [NUM_CH-1:0]    gnt_oh;
  logic [BUS_WIDTH-1:0] hold_reg [NUM_CH];
  logic [CH_W-1:0]      rr_ptr_reg, rr_ptr_next;
  logic [CH_W-1:0]      gnt_idx;
  logic                 gnt_found;
  logic                 grant;
  logic [BUS_WIDTH-1:0] sync_bus_reg;
  logic [CH_W-1:0]      sync_ch_reg;
  logic                 out_valid_reg;
  logic                 enable_pulse_reg;

  // One enable synchroniser and one holding register per channel.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    BIT_SYNC #(
      .WIDTH      (1),
      .NUM_STAGES (NUM_STAGES)
    ) u_bit_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (bus_enable[gi]),
      .sync_out (en_s[gi])
    );

    // Capture the source word on a rising synchronised enable when the slot is free.
    always_ff @(posedge clk) begin
      if (rst)               hold_reg[gi] <= {BUS_WIDTH{RST_BIT}};
      else if (load_hold[gi]) hold_reg[gi] <= Unsync_bus[gi*BUS_WIDTH +: BUS_WIDTH];
    end
  end

  // Round-robin search: first pending channel at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    int nxt;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_ptr_reg) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!gnt_found && pending_reg[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = CH_W'(idx);
      end
    end
    grant  = gnt_found && (!out_valid_reg || out_ready);
    gnt_oh = grant ? (NUM_CH'(1) << gnt_idx) : '0;
    // With one channel this always wraps to 0, so the pointer never moves.
    nxt = int'(gnt_idx) + 1;
    if (nxt >= NUM_CH) nxt = 0;
    rr_ptr_next = grant ? CH_W'(nxt) : rr_ptr_reg;
  end

  // Slot bookkeeping: a capture coinciding with a grant of the same channel
  // refills the slot instead of overrunning it.
  always_comb begin
    cap          = en_s & ~en_d_reg;
    load_hold    = cap & (~pending_reg | gnt_oh);
    pending_next = cap | (pending_reg & ~gnt_oh);
    overrun_next = (cap & pending_reg & ~gnt_oh) | (overrun_reg & ~err_clr);
  end

  // Edge-detect delay, pending/overrun flags and arbitration pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_d_reg    <= {NUM_CH{RST_BIT}};
      pending_reg <= {NUM_CH{RST_BIT}};
      overrun_reg <= {NUM_CH{RST_BIT}};
      rr_ptr_reg  <= {CH_W{RST_BIT}};
    end else begin
      en_d_reg    <= en_s;
      pending_reg <= pending_next;
      overrun_reg <= overrun_next;
      rr_ptr_reg  <= rr_ptr_next;
    end
  end

  // Output word register: load on grant, drop valid once accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_bus_reg     <= {BUS_WIDTH{RST_BIT}};
      sync_ch_reg      <= {CH_W{RST_BIT}};
      out_valid_reg    <= RST_BIT;
      enable_pulse_reg <= RST_BIT;
    end else begin
      enable_pulse_reg <= grant;
      if (grant) begin
        sync_bus_reg  <= hold_reg[gnt_idx];
        sync_ch_reg   <= gnt_idx;
        out_valid_reg <= 1'b1;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign sync_bus     = sync_bus_reg;
  assign sync_ch      = sync_ch_reg;
  assign out_valid    = out_valid_reg;
  assign enable_pulse = enable_pulse_reg;
  assign overrun      = overrun_reg;

`ifdef DATA_SYNC_MC_ACK_EN
  logic [NUM_CH-1:0] ack_reg;

  // Raise ack on the grant; it falls as soon as the synchronised enable drops.
  always_ff @(posedge clk) begin
    if (rst) ack_reg <= {NUM_CH{RST_BIT}};
    else     ack_reg <= gnt_oh | (ack_reg & en_s);
  end

  assign ack = ack_reg & en_s;
`else
  assign ack = '0;
`endif

endmodule

// File: tb/tb_data_sync_mc.sv
// Directed bench for data_sync_mc (BUS_WIDTH=8, NUM_STAGES=2, NUM_CH=4).
// Expected ack values follow DATA_SYNC_MC_ACK_EN when it is defined.
module tb_data_sync_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Unsync_bus;
  logic [3:0]  bus_enable;
  logic [3:0]  err_clr;
  logic        out_ready;
  logic [7:0]  sync_bus;
  logic [1:0]  sync_ch;
  logic        out_valid;
  logic        enable_pulse;
  logic [3:0]  overrun;
  logic [3:0]  ack;

  int n_cmp = 0;
  int n_mis = 0;

`ifdef DATA_SYNC_MC_ACK_EN
  localparam logic [3:0] ACK3 = 4'b1000;
`else
  localparam logic [3:0] ACK3 = 4'b0000;
`endif

  data_sync_mc #(
    .BUS_WIDTH  (8),
    .NUM_STAGES (2),
    .NUM_CH     (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .Unsync_bus   (Unsync_bus),
    .bus_enable   (bus_enable),
    .err_clr      (err_clr),
    .out_ready    (out_ready),
    .sync_bus     (sync_bus),
    .sync_ch      (sync_ch),
    .out_valid    (out_valid),
    .enable_pulse (enable_pulse),
    .overrun      (overrun),
    .ack          (ack)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int c, input logic [7:0] v);
    Unsync_bus[c*8 +: 8] = v;
  endtask

  task automatic check_word(input string tag, input logic [7:0] bus, input logic [1:0] ch);
    check({tag, "_pulse"}, enable_pulse, 1'b1);
    check({tag, "_bus"}, sync_bus, bus);
    check({tag, "_ch"}, sync_ch, ch);
    check({tag, "_valid"}, out_valid, 1'b1);
  endtask

  initial begin
    bit stale;
    rst        = 1'b1;
    Unsync_bus = '0;
    bus_enable = '0;
    err_clr    = '0;
    out_ready  = 1'b0;
    tick(2);
    check("rst_valid", out_valid, 1'b0);
    check("rst_pulse", enable_pulse, 1'b0);
    check("rst_bus", sync_bus, 8'h00);
    check("rst_overrun", overrun, 4'h0);
    check("rst_ack", ack, 4'h0);
    rst = 1'b0;
    tick(1);

    // Round robin: all four rise together, delivered 0,1,2,3 back to back.
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) set_data(c, 8'h10 + 8'(c));
    bus_enable = 4'hF;
    tick(4);
    check_word("rr0", 8'h10, 2'd0);
    tick(1);
    check_word("rr1", 8'h11, 2'd1);
    tick(1);
    check_word("rr2", 8'h12, 2'd2);
    tick(1);
    check_word("rr3", 8'h13, 2'd3);
    tick(1);
    check("rr_done_valid", out_valid, 1'b0);
    check("rr_done_pulse", enable_pulse, 1'b0);
    bus_enable = 4'h0;
    tick(3);
    // ch1 and ch0 together with rr_ptr back at 0: ch0 first.
    set_data(0, 8'h20);
    set_data(1, 8'h21);
    bus_enable = 4'b0011;
    tick(4);
    check_word("pair0", 8'h20, 2'd0);
    tick(1);
    check_word("pair1", 8'h21, 2'd1);
    bus_enable = 4'h0;
    tick(3);

    // Single capture on ch2: pulse exactly four cycles after the enable rises.
    set_data(2, 8'hA5);
    bus_enable = 4'b0100;
    tick(3);
    check("single_early_pulse", enable_pulse, 1'b0);
    check("single_early_valid", out_valid, 1'b0);
    tick(1);
    check_word("single", 8'hA5, 2'd2);
    tick(1);
    check("single_pulse_off", enable_pulse, 1'b0);
    check("single_valid_off", out_valid, 1'b0);
    bus_enable = 4'h0;
    tick(3);

    // Backpressure: rr_ptr=3, ch0 and ch3 pending, consumer stalled.
    out_ready = 1'b0;
    set_data(0, 8'h30);
    set_data(3, 8'h33);
    bus_enable = 4'b1001;
    tick(4);
    check_word("bp_first", 8'h33, 2'd3);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("bp_hold_bus", sync_bus, 8'h33);
      check("bp_hold_valid", out_valid, 1'b1);
    end
    check("bp_hold_pulse", enable_pulse, 1'b0);
    out_ready = 1'b1;
    tick(1);
    check_word("bp_second", 8'h30, 2'd0);
    tick(1);
    check("bp_drain_valid", out_valid, 1'b0);
    bus_enable = 4'h0;
    tick(3);

    // Overrun: park a ch0 word in the output, then ch1 captures twice.
    out_ready = 1'b0;
    set_data(0, 8'h40);
    bus_enable = 4'b0001;
    tick(4);
    check_word("ovr_park", 8'h40, 2'd0);
    bus_enable = 4'b0010;
    set_data(1, 8'h11);
    tick(3);
    check("ovr_first_clean", overrun, 4'h0);
    bus_enable = 4'b0000;
    tick(3);
    set_data(1, 8'h22);
    bus_enable = 4'b0010;
    tick(3);
    check("ovr_set", overrun, 4'b0010);
    check("ovr_parked_bus", sync_bus, 8'h40);
    out_ready = 1'b1;
    tick(1);
    check_word("ovr_deliver", 8'h11, 2'd1);
    tick(1);
    check("ovr_sticky", overrun, 4'b0010);
    check("ovr_no_extra", out_valid, 1'b0);
    err_clr = 4'b0010;
    tick(1);
    err_clr = 4'b0000;
    check("ovr_cleared", overrun, 4'h0);
    bus_enable = 4'h0;
    tick(3);

    // Reset mid-operation: ch2 parked at output, ch0/ch1 pending.
    out_ready = 1'b0;
    set_data(0, 8'h50);
    set_data(1, 8'h51);
    set_data(2, 8'h52);
    bus_enable = 4'b0111;
    tick(4);
    check_word("mid_park", 8'h52, 2'd2);
    tick(1);
    rst = 1'b1;
    tick(1);
    check("mid_rst_bus", sync_bus, 8'h00);
    check("mid_rst_ch", sync_ch, 2'd0);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_pulse", enable_pulse, 1'b0);
    check("mid_rst_overrun", overrun, 4'h0);
    check("mid_rst_ack", ack, 4'h0);
    rst        = 1'b0;
    bus_enable = 4'h0;
    out_ready  = 1'b1;
    stale      = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (out_valid || enable_pulse) stale = 1'b1;
    end
    check("mid_no_stale", stale, 1'b0);

    // Acknowledge on ch3: rises with the grant, falls two cycles after the enable drops.
    set_data(3, 8'h77);
    bus_enable = 4'b1000;
    tick(3);
    check("ack_before_grant", ack, 4'h0);
    tick(1);
    check_word("ack_grant", 8'h77, 2'd3);
    check("ack_rise", ack, ACK3);
    tick(1);
    check("ack_hold", ack, ACK3);
    bus_enable = 4'h0;
    tick(1);
    check("ack_fall_1", ack, ACK3);
    tick(1);
    check("ack_fall_2", ack, 4'h0);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
